// File: rtl/spi_ctrl_master.sv
// spi_ctrl_master: SPI mode-1 controller issuing one rw/addr/data frame per start request.
// Define SPI_CTRL_MISO_SYNC_EN to add a 2-flop miso synchroniser with late-in-period sampling.
module spi_ctrl_master #(
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 3,
   parameter int CLK_DIV    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  rw,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [WIDTH-1:0]      wdata,
   output logic                  busy,
   output logic                  done,
   output logic [WIDTH-1:0]      rdata,
   output logic                  spi_cs_n,
   output logic                  spi_clk,
   output logic                  spi_mosi,
   input  logic                  spi_miso
);

   localparam int FRAME_W = 8 + WIDTH;
`ifdef SPI_CTRL_MISO_SYNC_EN
   localparam int MIN_DIV = 3;
`else
   localparam int MIN_DIV = 2;
`endif
   localparam int DW = $clog2(CLK_DIV + 1);
   localparam int BW = $clog2(FRAME_W);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_GAP  = DW'(CLK_DIV);
   localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_W - 1);

   generate
      if (CLK_DIV < MIN_DIV) begin : g_bad_div
         $error("spi_ctrl_master: CLK_DIV below minimum for this build");
      end
      if (ADDR_WIDTH > 7 || ADDR_WIDTH < 1) begin : g_bad_addr
         $error("spi_ctrl_master: ADDR_WIDTH must be 1..7");
      end
      if (WIDTH < 2) begin : g_bad_width
         $error("spi_ctrl_master: WIDTH must be >= 2");
      end
   endgenerate

   typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, CS_GAP} state_t;

   state_t              state;
   logic [DW-1:0]       div_cnt;
   logic [BW-1:0]       bit_cnt;
   logic [FRAME_W-1:0]  frame;
   logic [WIDTH-1:0]    shreg;
   logic                rw_q;
   logic                miso_bit;

`ifdef SPI_CTRL_MISO_SYNC_EN
   // Sample at the end of the low half so the 2-cycle synchroniser delay stays inside the bit period.
   localparam logic SAMPLE_PHASE = 1'b0;
   logic [1:0] miso_sync;

   always_ff @(posedge clk) begin
      if (rst) miso_sync <= '0;
      else     miso_sync <= {miso_sync[0], spi_miso};
   end
   assign miso_bit = miso_sync[1];
`else
   localparam logic SAMPLE_PHASE = 1'b1;
   assign miso_bit = spi_miso;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         div_cnt  <= '0;
         bit_cnt  <= '0;
         frame    <= '0;
         shreg    <= '0;
         rw_q     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         rdata    <= '0;
         spi_cs_n <= 1'b1;
         spi_clk  <= 1'b0;
         spi_mosi <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == SHIFT && div_cnt == DIV_LAST && spi_clk == SAMPLE_PHASE)
            shreg <= {shreg[WIDTH-2:0], miso_bit};

         case (state)
            IDLE: begin
               div_cnt <= '0;
               // done gates accept so a start coinciding with the done pulse is dropped
               if (start && !done) begin
                  rw_q     <= rw;
                  frame    <= {rw, 7'(addr), wdata & {WIDTH{rw}}};
                  busy     <= 1'b1;
                  spi_cs_n <= 1'b0;
                  state    <= CS_SETUP;
               end
            end
            CS_SETUP: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt  <= '0;
                  spi_clk  <= 1'b1;
                  spi_mosi <= frame[FRAME_W-1];
                  frame    <= {frame[FRAME_W-2:0], 1'b0};
                  bit_cnt  <= BIT_LAST;
                  state    <= SHIFT;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            SHIFT: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  if (spi_clk) begin
                     spi_clk <= 1'b0;
                  end else if (bit_cnt == '0) begin
                     state <= CS_HOLD;
                  end else begin
                     bit_cnt  <= bit_cnt - 1'b1;
                     spi_clk  <= 1'b1;
                     spi_mosi <= frame[FRAME_W-1];
                     frame    <= {frame[FRAME_W-2:0], 1'b0};
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            CS_HOLD: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt  <= '0;
                  spi_cs_n <= 1'b1;
                  spi_mosi <= 1'b0;
                  state    <= CS_GAP;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            CS_GAP: begin
               // Gap runs H+1 cycles so done lands 35*H+1 cycles after accept.
               if (div_cnt == DIV_GAP) begin
                  div_cnt <= '0;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  if (!rw_q) rdata <= shreg;
                  state   <= IDLE;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_ctrl_master.sv
// Self-checking bench for spi_ctrl_master: vector table plus scoreboard checked on each done pulse.
module tb_spi_ctrl_master;

`ifdef SPI_CTRL_MISO_SYNC_EN
   localparam int H = 3;
`else
   localparam int H = 4;
`endif
   localparam int LIM = 40 * H + 50;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       rw;
   logic [2:0] addr;
   logic [7:0] wdata;
   logic       busy;
   logic       done;
   logic [7:0] rdata;
   logic       spi_cs_n;
   logic       spi_clk;
   logic       spi_mosi;
   logic       spi_miso;

   logic        loop_en = 1'b0;
   logic        model_miso = 1'b0;
   logic [15:0] p_resp = '0;
   logic [15:0] p_cap = '0;
   int          p_idx = 0;
   int          p_rises = 0;

   int n_checks = 0;
   int n_fail   = 0;
   int n_done   = 0;
   int cyc      = 0;
   int low_cnt  = 0;
   int hi_run   = 0;
   int last_gap = 0;

   typedef struct {
      logic [15:0] frame;
      logic [7:0]  rdata;
      int          acc;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic        rw;
      logic [2:0]  addr;
      logic [7:0]  wdata;
      logic [7:0]  resp;
      logic        loop;
      logic [15:0] exp_frame;
      logic [7:0]  exp_rdata;
   } vec_t;

   assign spi_miso = loop_en ? spi_mosi : model_miso;

   spi_ctrl_master #(.WIDTH(8), .ADDR_WIDTH(3), .CLK_DIV(H)) dut (
      .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
      .busy(busy), .done(done), .rdata(rdata),
      .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out after %0d cycles", name, LIM);
   endtask

   // Peripheral: drives miso on sclk rise, captures mosi on sclk fall.
   initial begin : periph
      logic cs_q;
      logic clk_q;
      cs_q  = 1'b1;
      clk_q = 1'b0;
      forever begin
         @(spi_cs_n or spi_clk);
         if (cs_q === 1'b1 && spi_cs_n === 1'b0) begin
            p_cap   = '0;
            p_idx   = 0;
            p_rises = 0;
         end
         if (clk_q === 1'b0 && spi_clk === 1'b1) begin
            if (p_idx < 16) model_miso = p_resp[15 - p_idx];
            p_idx++;
            p_rises++;
         end
         if (clk_q === 1'b1 && spi_clk === 1'b0) p_cap = {p_cap[14:0], spi_mosi};
         cs_q  = spi_cs_n;
         clk_q = spi_clk;
      end
   end

   initial begin : monitor
      exp_t e;
      logic cs_prev;
      cs_prev = 1'b1;
      forever begin
         @(negedge clk);
         if (spi_cs_n === 1'b0) begin
            if (cs_prev) begin
               low_cnt  = 0;
               last_gap = hi_run;
            end
            hi_run = 0;
            low_cnt++;
         end else begin
            hi_run++;
         end
         cs_prev = spi_cs_n;
         if (done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pulse", cyc);
            end else begin
               e = sb.pop_front();
               check("frame", p_cap, e.frame);
               check("sclk_rises", p_rises, 16);
               check("cs_low_cycles", low_cnt, 34 * H);
               check("rdata", rdata, e.rdata);
               check("busy_at_done", busy, 0);
               if (e.acc >= 0) check("done_latency", cyc - e.acc, 35 * H + 1);
            end
         end
      end
   end

   task automatic issue(input logic r, input logic [2:0] a, input logic [7:0] d,
                        input logic [15:0] fr, input logic [7:0] rd, input bit chk_lat);
      exp_t e;
      @(negedge clk);
      start = 1'b1;
      rw    = r;
      addr  = a;
      wdata = d;
      e.frame = fr;
      e.rdata = rd;
      e.acc   = chk_lat ? cyc + 1 : -1;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      check("busy_after_accept", busy, 1);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((sb.size() != 0 || busy !== 1'b0) && n < LIM) begin
         @(negedge clk);
         n++;
      end
      if (n >= LIM) timeout_fail(name);
   endtask

   initial begin : main
      vec_t vt[7];
      int   d0;
      int   n;

      rst = 1'b1; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
      vt[0] = '{1'b0, 3'd7, 8'h00, 8'h00, 1'b1, 16'h0700, 8'h00};
      vt[1] = '{1'b1, 3'd7, 8'hFF, 8'h00, 1'b1, 16'h87FF, 8'h00};
      vt[2] = '{1'b0, 3'd5, 8'h00, 8'h3C, 1'b0, 16'h0500, 8'h3C};
      vt[3] = '{1'b1, 3'd3, 8'hA5, 8'h99, 1'b0, 16'h83A5, 8'h3C};
      vt[4] = '{1'b0, 3'd2, 8'h00, 8'h5A, 1'b0, 16'h0200, 8'h5A};
      vt[5] = '{1'b1, 3'd0, 8'h00, 8'hC3, 1'b0, 16'h8000, 8'h5A};
      vt[6] = '{1'b0, 3'd6, 8'h00, 8'hFF, 1'b0, 16'h0600, 8'hFF};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_rdata", rdata, 8'h00);
      check("reset_cs_n", spi_cs_n, 1);
      check("reset_sclk", spi_clk, 0);
      check("reset_mosi", spi_mosi, 0);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         loop_en = vt[i].loop;
         p_resp  = {8'h00, vt[i].resp};
         issue(vt[i].rw, vt[i].addr, vt[i].wdata, vt[i].exp_frame, vt[i].exp_rdata, 1'b1);
         wait_idle("vector_wait");
      end

      // Reset in the middle of a read frame
      loop_en = 1'b0;
      p_resp  = 16'h0077;
      d0 = n_done;
      issue(1'b0, 3'd1, 8'h00, 16'h0100, 8'h77, 1'b0);
      repeat (6 * H) @(negedge clk);
      check("mid_shift_cs_low", spi_cs_n, 0);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_cs_n", spi_cs_n, 1);
         check("rst_sclk", spi_clk, 0);
         check("rst_mosi", spi_mosi, 0);
         check("rst_busy", busy, 0);
         check("rst_rdata", rdata, 8'h00);
      end
      rst = 1'b0;
      sb.delete();
      repeat (45 * H) @(negedge clk);
      check("rst_no_done", n_done - d0, 0);

      // Second start mid-transaction is dropped
      d0 = n_done;
      issue(1'b1, 3'd4, 8'h3C, 16'h843C, 8'h00, 1'b1);
      repeat (10 * H) @(negedge clk);
      start = 1'b1; rw = 1'b0; addr = 3'd1;
      @(negedge clk);
      start = 1'b0;
      wait_idle("busy_ignore_wait");
      repeat (4 * H) @(negedge clk);
      check("busy_ignore_dones", n_done - d0, 1);
      check("busy_ignore_idle", busy, 0);

      // start held high: back-to-back frames
      d0 = n_done;
      @(negedge clk);
      start = 1'b1; rw = 1'b1; addr = 3'd2; wdata = 8'h81;
      sb.push_back('{16'h8281, 8'h00, cyc + 1});
      sb.push_back('{16'h8281, 8'h00, -1});
      n = 0;
      while (n_done - d0 < 1 && n < LIM) begin @(negedge clk); n++; end
      if (n >= LIM) timeout_fail("b2b_first_done");
      n = 0;
      while (busy !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
      if (n >= LIM) timeout_fail("b2b_second_accept");
      start = 1'b0;
      wait_idle("b2b_wait");
      check("b2b_dones", n_done - d0, 2);
      check("b2b_gap_ge_h", last_gap >= H, 1);

      // start present only in the done cycle is ignored
      issue(1'b1, 3'd5, 8'h11, 16'h8511, 8'h00, 1'b1);
      n = 0;
      while (done !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
      if (n >= LIM) timeout_fail("done_cycle_wait");
      d0 = n_done;
      start = 1'b1; rw = 1'b0; addr = 3'd6;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("done_cycle_start_busy", busy, 0);
      check("done_cycle_start_cs", spi_cs_n, 1);
      repeat (40 * H) @(negedge clk);
      check("done_cycle_start_no_frame", n_done - d0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
